// File: rtl/ac_ctrl_pkg.sv
// Shared types for the arithmetic-core layer sequencer: FSM states, widths and
// the core configuration bundle.
package ac_ctrl_pkg;

    localparam int unsigned IN_W   = 72;
    localparam int unsigned BIAS_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StArm,
        StStream,
        StDrain,
        StDone
    } seq_state_e;

    typedef struct packed {
        logic signed [BIAS_W-1:0] bias;
        logic [1:0]               bound_level;
        logic [2:0]               step;
        logic                     relu;
        logic                     mp;
    } core_cfg_t;

endpackage

// File: rtl/ac_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last load/kick and flags
// expiry once MaxIdle cycles have elapsed without activity.
module ac_watchdog #(
    parameter int unsigned MaxIdle = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic kick_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(MaxIdle + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || kick_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CntW'(MaxIdle));

endmodule

// File: rtl/ac_layer_sequencer.sv
// Drives one arithmetic core through a layer pass: clear, arm, stream windows in,
// collect results out, and finish on completion or drain timeout.
module ac_layer_sequencer
    import ac_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned CLR_CYC   = 2,
    parameter int unsigned DRAIN_MAX = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CNT_W-1:0]         cfg_num_windows,
    input  logic signed [BIAS_W-1:0] cfg_bias,
    input  logic [1:0]               cfg_bound_level,
    input  logic [2:0]               cfg_step,
    input  logic                     cfg_relu,
    input  logic                     cfg_mp,
    input  logic                     win_valid,
    output logic                     win_ready,
    input  logic [IN_W-1:0]          win_data,
    output logic [IN_W-1:0]          ac_in,
    output logic                     ac_en,
    output logic signed [BIAS_W-1:0] ac_bias,
    output logic [1:0]               ac_bound_level,
    output logic [2:0]               ac_step,
    output logic                     ac_en_relu,
    output logic                     ac_en_mp,
    output logic                     ac_reset_n,
    input  logic [7:0]               ac_out,
    input  logic                     ac_out_en,
    output logic                     res_valid,
    output logic [7:0]               res_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     err_overrun
);

    localparam int unsigned CLR_W = $clog2(CLR_CYC + 1);

    seq_state_e       state_q, state_d;
    core_cfg_t        cfg_q, cfg_d;
    core_cfg_t        core_q, core_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] rcv_q, rcv_d;
    logic [CLR_W-1:0] clr_q, clr_d;
    logic [IN_W-1:0]  ac_in_q, ac_in_d;
    logic             ac_en_q, ac_en_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_overrun_q, err_overrun_d;

    logic cfg_accept, win_hs, collect, wd_expired;

    assign cfg_accept = cfg_valid && cfg_ready && !reset;
    assign win_hs     = win_valid && win_ready;
    // Results are only accepted while a pass is live and still short of its quota.
    assign collect    = (state_q == StStream || state_q == StDrain || state_q == StDone)
                        && (rcv_q != exp_q);

    ac_watchdog #(
        .MaxIdle(DRAIN_MAX)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_i    (reset),
        .load_i   (state_q != StDrain),
        .kick_i   (ac_out_en),
        .en_i     (state_q == StDrain),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_accept) begin
                    state_d = (cfg_num_windows == '0) ? StDone : StClear;
                end
            end
            StClear:  if (clr_q == CLR_W'(CLR_CYC - 1)) state_d = StArm;
            StArm:    state_d = StStream;
            StStream: if (sent_q == num_q) state_d = StDrain;
            StDrain:  if (rcv_q == exp_q || wd_expired) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cfg_ready  = reset || (state_q == StIdle);
        win_ready  = !reset && (state_q == StStream) && (sent_q != num_q);
        busy       = !reset && (state_q != StIdle);
        done       = !reset && (state_q == StDone);
        ac_reset_n = !reset && (state_q != StClear);
    end

    always_comb begin
        cfg_d         = cfg_q;
        core_d        = core_q;
        num_d         = num_q;
        exp_d         = exp_q;
        sent_d        = sent_q;
        rcv_d         = rcv_q;
        clr_d         = '0;
        ac_in_d       = ac_in_q;
        ac_en_d       = 1'b0;
        res_valid_d   = 1'b0;
        res_data_d    = res_data_q;
        err_timeout_d = err_timeout_q;
        err_overrun_d = err_overrun_q;

        if (cfg_accept) begin
            cfg_d.bias        = cfg_bias;
            cfg_d.bound_level = cfg_bound_level;
            cfg_d.step        = cfg_step;
            cfg_d.relu        = cfg_relu;
            cfg_d.mp          = cfg_mp;
            num_d             = cfg_num_windows;
            // Pooling folds 4 windows per output; a trailing partial group yields nothing.
            exp_d             = cfg_mp ? (cfg_num_windows >> 2) : cfg_num_windows;
            sent_d            = '0;
            rcv_d             = '0;
            err_timeout_d     = 1'b0;
            err_overrun_d     = 1'b0;
        end

        if (state_q == StClear) clr_d = clr_q + 1'b1;
        if (state_d == StArm) core_d = cfg_q;

        if (win_hs) begin
            ac_in_d = win_data;
            ac_en_d = 1'b1;
            sent_d  = sent_q + 1'b1;
        end

        if (ac_out_en) begin
            if (collect) begin
                res_valid_d = 1'b1;
                res_data_d  = ac_out;
                rcv_d       = rcv_q + 1'b1;
            end else begin
                err_overrun_d = 1'b1;
            end
        end

        if (state_q == StDrain && rcv_q != exp_q && wd_expired) err_timeout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q         <= '0;
            core_q        <= '0;
            num_q         <= '0;
            exp_q         <= '0;
            sent_q        <= '0;
            rcv_q         <= '0;
            clr_q         <= '0;
            ac_in_q       <= '0;
            ac_en_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            cfg_q         <= cfg_d;
            core_q        <= core_d;
            num_q         <= num_d;
            exp_q         <= exp_d;
            sent_q        <= sent_d;
            rcv_q         <= rcv_d;
            clr_q         <= clr_d;
            ac_in_q       <= ac_in_d;
            ac_en_q       <= ac_en_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign ac_in          = ac_in_q;
    assign ac_en          = ac_en_q;
    assign ac_bias        = core_q.bias;
    assign ac_bound_level = core_q.bound_level;
    assign ac_step        = core_q.step;
    assign ac_en_relu     = core_q.relu;
    assign ac_en_mp       = core_q.mp;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign err_timeout    = err_timeout_q;
    assign err_overrun    = err_overrun_q;

endmodule

// File: tb/tb_ac_layer_sequencer.sv
// Directed bench for ac_layer_sequencer with a small behavioural core model
// (3-cycle latency, optional 2x2 max-pool, optional dropped output).
module tb_ac_layer_sequencer;
    import ac_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [11:0]       cfg_num_windows;
    logic signed [15:0] cfg_bias;
    logic [1:0]        cfg_bound_level;
    logic [2:0]        cfg_step;
    logic              cfg_relu;
    logic              cfg_mp;
    logic              win_valid;
    logic              win_ready;
    logic [71:0]       win_data;
    logic [71:0]       ac_in;
    logic              ac_en;
    logic signed [15:0] ac_bias;
    logic [1:0]        ac_bound_level;
    logic [2:0]        ac_step;
    logic              ac_en_relu;
    logic              ac_en_mp;
    logic              ac_reset_n;
    logic [7:0]        ac_out;
    logic              ac_out_en;
    logic              res_valid;
    logic [7:0]        res_data;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic              err_overrun;

    always #5 clk = ~clk;

    ac_layer_sequencer #(
        .CNT_W    (12),
        .CLR_CYC  (2),
        .DRAIN_MAX(64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_num_windows(cfg_num_windows),
        .cfg_bias       (cfg_bias),
        .cfg_bound_level(cfg_bound_level),
        .cfg_step       (cfg_step),
        .cfg_relu       (cfg_relu),
        .cfg_mp         (cfg_mp),
        .win_valid      (win_valid),
        .win_ready      (win_ready),
        .win_data       (win_data),
        .ac_in          (ac_in),
        .ac_en          (ac_en),
        .ac_bias        (ac_bias),
        .ac_bound_level (ac_bound_level),
        .ac_step        (ac_step),
        .ac_en_relu     (ac_en_relu),
        .ac_en_mp       (ac_en_mp),
        .ac_reset_n     (ac_reset_n),
        .ac_out         (ac_out),
        .ac_out_en      (ac_out_en),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .busy           (busy),
        .done           (done),
        .err_timeout    (err_timeout),
        .err_overrun    (err_overrun)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] win_of(input int i, input int seed);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'((i * 7 + k * 13 + seed * 29 + i * i) & 255);
        return w;
    endfunction

    function automatic logic [7:0] f_of(input logic [71:0] w, input logic [15:0] bias);
        return w[7:0] ^ w[71:64] ^ bias[7:0];
    endfunction

    function automatic logic [7:0] gold(input int j, input logic mp, input logic [15:0] bias,
                                        input int seed);
        logic [7:0] m, v;
        if (!mp) return f_of(win_of(j, seed), bias);
        m = 8'd0;
        for (int q = 0; q < 4; q++) begin
            v = f_of(win_of(4 * j + q, seed), bias);
            if (v > m) m = v;
        end
        return m;
    endfunction

    // Behavioural core model.
    logic [7:0] m_d0, m_d1, m_d2;
    logic       m_v0, m_v1, m_v2;
    logic [1:0] m_grp;
    logic [7:0] m_max;
    logic [7:0] m_v, m_mx;
    int         m_emit;
    int         drop_idx = -1;

    always @(posedge clk) begin
        if (!ac_reset_n) begin
            m_v0 <= 1'b0; m_v1 <= 1'b0; m_v2 <= 1'b0;
            m_d0 <= 8'd0; m_d1 <= 8'd0; m_d2 <= 8'd0;
            m_grp <= 2'd0; m_max <= 8'd0; m_emit <= 0;
        end else begin
            m_v1 <= m_v0; m_d1 <= m_d0;
            m_v2 <= m_v1; m_d2 <= m_d1;
            m_v0 <= 1'b0;
            if (ac_en) begin
                m_v = f_of(ac_in, ac_bias);
                if (!ac_en_mp) begin
                    m_v0   <= (m_emit != drop_idx);
                    m_d0   <= m_v;
                    m_emit <= m_emit + 1;
                end else begin
                    m_mx  = (m_grp == 2'd0 || m_v > m_max) ? m_v : m_max;
                    m_max <= m_mx;
                    m_grp <= m_grp + 2'd1;
                    if (m_grp == 2'd3) begin
                        m_v0   <= (m_emit != drop_idx);
                        m_d0   <= m_mx;
                        m_emit <= m_emit + 1;
                    end
                end
            end
        end
    end
    assign ac_out    = m_d2;
    assign ac_out_en = m_v2;

    // Window source.
    logic drv_en = 1'b0;
    int   drv_num = 0, drv_gap = 1, drv_seed = 0, drv_idx = 0, wcyc = 0;
    logic hs;

    initial begin
        win_valid = 1'b0;
        win_data  = '0;
        forever begin
            @(negedge clk);
            hs = win_valid && win_ready;
            @(posedge clk);
            #1;
            if (!drv_en) drv_idx = 0;
            else if (hs) drv_idx++;
            wcyc++;
            win_valid = drv_en && (drv_idx < drv_num) && (wcyc % drv_gap == 0);
            win_data  = win_of(drv_idx, drv_seed);
        end
    end

    // Monitor (only increments; the main sequence works on deltas).
    logic [7:0] res_log[$];
    int   mcyc = 0, done_cnt = 0, rstn_low_cnt = 0, en_cnt = 0, en_consec = 0;
    int   mp_low_cnt = 0, wr_bad = 0, last_res_cyc = 0, done_cyc = 0;
    logic prev_en = 1'b0, seen_clear = 1'b0;

    always @(negedge clk) begin
        mcyc++;
        if (res_valid) begin
            res_log.push_back(res_data);
            last_res_cyc = mcyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = mcyc;
        end
        if (!reset && !ac_reset_n) rstn_low_cnt++;
        if (ac_en) en_cnt++;
        if (ac_en && prev_en) en_consec++;
        prev_en = ac_en;
        if (!busy) seen_clear = 1'b0;
        else if (!ac_reset_n) seen_clear = 1'b1;
        else if (seen_clear && !ac_en_mp) mp_low_cnt++;
        if (win_ready && !busy) wr_bad++;
    end

    int   b_res, b_done, b_rstn, b_en, b_consec, b_mp, done_k;
    logic timed_out;

    task automatic snapshot();
        b_res = res_log.size(); b_done = done_cnt; b_rstn = rstn_low_cnt;
        b_en = en_cnt; b_consec = en_consec; b_mp = mp_low_cnt;
    endtask

    task automatic issue_cfg(input int num, input logic mp, input logic [2:0] step,
                             input logic [15:0] bias, input int gap, input int seed);
        @(posedge clk);
        #1;
        drv_num = num; drv_gap = gap; drv_seed = seed; drv_en = 1'b1;
        cfg_valid = 1'b1; cfg_num_windows = 12'(num); cfg_bias = bias;
        cfg_bound_level = 2'b01; cfg_step = step; cfg_relu = 1'b1; cfg_mp = mp;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        timed_out = 1'b1;
        done_k = budget;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_cnt != b_done) begin
                timed_out = 1'b0;
                done_k = k;
                break;
            end
        end
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        drv_en = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic run_pass(input int num, input logic mp, input logic [2:0] step,
                            input logic [15:0] bias, input int gap, input int seed);
        snapshot();
        issue_cfg(num, mp, step, bias, gap, seed);
        wait_done(2000);
    endtask

    task automatic check_results(input string tag, input int n, input logic mp,
                                 input logic [15:0] bias, input int seed);
        int bad;
        bad = 0;
        for (int j = 0; j < n && (b_res + j) < res_log.size(); j++) begin
            if (res_log[b_res + j] !== gold(j, mp, bias, seed)) begin
                if (bad == 0) check_eq({tag, "_data"}, res_log[b_res + j], gold(j, mp, bias, seed));
                bad++;
            end
        end
        check_eq({tag, "_data_mismatches"}, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_num_windows = '0; cfg_bias = '0;
        cfg_bound_level = '0; cfg_step = '0; cfg_relu = 1'b0; cfg_mp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cfg_ready", cfg_ready, 1);
        check_eq("rst_outputs", {busy, done, win_ready, ac_en, res_valid, ac_reset_n,
                                 err_timeout, err_overrun, ac_en_mp}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("idle_ac_reset_n", ac_reset_n, 1);

        // 1: plain pass, back-to-back windows.
        run_pass(64, 1'b0, 3'b000, 16'h0000, 1, 1);
        check_eq("t1_done_seen", timed_out, 0);
        check_eq("t1_res_count", res_log.size() - b_res, 64);
        check_results("t1", 64, 1'b0, 16'h0000, 1);
        check_eq("t1_done_count", done_cnt - b_done, 1);
        check_eq("t1_en_count", en_cnt - b_en, 64);
        check_eq("t1_errs", {err_timeout, err_overrun}, 0);

        // 2: max-pool pass.
        run_pass(64, 1'b1, 3'b000, 16'h0035, 1, 2);
        check_eq("t2_res_count", res_log.size() - b_res, 16);
        check_results("t2", 16, 1'b1, 16'h0035, 2);
        check_eq("t2_mp_low_cycles", mp_low_cnt - b_mp, 0);
        check_eq("t2_errs", {err_timeout, err_overrun}, 0);

        // 3: max-pool with windows arriving every third cycle.
        run_pass(64, 1'b1, 3'b001, 16'hFF80, 3, 3);
        check_eq("t3_done_count", done_cnt - b_done, 1);
        check_eq("t3_res_count", res_log.size() - b_res, 16);
        check_results("t3", 16, 1'b1, 16'hFF80, 3);
        check_eq("t3_en_count", en_cnt - b_en, 64);
        check_eq("t3_en_back_to_back", en_consec - b_consec, 0);

        // 4: empty pass.
        run_pass(0, 1'b0, 3'b000, 16'h0000, 1, 4);
        check_eq("t4_done_within_2", (!timed_out && done_k + 1 <= 2), 1);
        check_eq("t4_ac_reset_n_low", rstn_low_cnt - b_rstn, 0);
        check_eq("t4_en_count", en_cnt - b_en, 0);
        check_eq("t4_res_count", res_log.size() - b_res, 0);

        // 5: core loses the last output -> drain timeout.
        drop_idx = 15;
        run_pass(16, 1'b0, 3'b000, 16'h0011, 1, 5);
        drop_idx = -1;
        check_eq("t5_done_count", done_cnt - b_done, 1);
        check_eq("t5_err_timeout", err_timeout, 1);
        check_eq("t5_err_overrun", err_overrun, 0);
        check_eq("t5_res_count", res_log.size() - b_res, 15);
        check_results("t5", 15, 1'b0, 16'h0011, 5);
        check_eq("t5_idle_gap_in_range",
                 (done_cyc - last_res_cyc >= 64 && done_cyc - last_res_cyc <= 70), 1);

        // 6: reset mid-stream, then a clean pass.
        snapshot();
        issue_cfg(64, 1'b0, 3'b000, 16'h0000, 1, 6);
        timed_out = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (drv_idx >= 30) begin
                timed_out = 1'b0;
                break;
            end
        end
        check_eq("t6_reached_window_30", timed_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drv_en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("t6_cfg_ready", cfg_ready, 1);
        check_eq("t6_win_ready", win_ready, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_ac_en", ac_en, 0);
        repeat (4) @(posedge clk);
        run_pass(8, 1'b0, 3'b000, 16'h0007, 1, 7);
        check_eq("t6_new_done_count", done_cnt - b_done, 1);
        check_eq("t6_new_res_count", res_log.size() - b_res, 8);
        check_results("t6", 8, 1'b0, 16'h0007, 7);
        check_eq("t6_new_errs", {err_timeout, err_overrun}, 0);
        check_eq("win_ready_outside_busy", wr_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
